// File: rtl/axi4_stream_arbiter.sv
// axi4_stream_arbiter: four-input AXI4-Stream packet arbiter.
// A round-robin pointer picks the next enabled requester while idle. The
// grant is then held for a whole packet, up to and including its tlast beat.
// The merged output mirrors the granted source combinationally.
module axi4_stream_arbiter #(
    parameter int DATA_WIDTH   = 32,
    parameter int STROBE_WIDTH = DATA_WIDTH / 8,
    parameter int NUM_PORTS    = 4
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic [NUM_PORTS-1:0]              i_enable,
    input  logic [NUM_PORTS-1:0]              i_tvalid,
    input  logic [NUM_PORTS*DATA_WIDTH-1:0]   i_tdata,
    input  logic [NUM_PORTS-1:0]              i_tlast,
    input  logic [NUM_PORTS*STROBE_WIDTH-1:0] i_tkeep,
    input  logic [NUM_PORTS*4-1:0]            i_tuser,
    output logic [NUM_PORTS-1:0]              o_tready,
    output logic                              o_tvalid,
    output logic [DATA_WIDTH-1:0]             o_tdata,
    output logic                              o_tlast,
    output logic [STROBE_WIDTH-1:0]           o_tkeep,
    output logic [3:0]                        o_tuser,
    output logic [3:0]                        o_tid,
    input  logic                              i_tready,
    output logic                              o_busy,
    output logic [31:0]                       o_pkt_count
);

    localparam logic [0:0] ST_IDLE  = 1'b0;
    localparam logic [0:0] ST_GRANT = 1'b1;

    logic [0:0]  state_q, state_d;
    logic [1:0]  ptr_q, ptr_d;
    logic [1:0]  grant_q, grant_d;
    logic [31:0] pkt_count_q, pkt_count_d;

    logic [NUM_PORTS-1:0] req;
    logic [1:0]           pick;
    logic [1:0]           cand;
    logic                 found;
    logic                 last_xfer;

    logic [DATA_WIDTH-1:0]   tdata_arr [NUM_PORTS];
    logic [STROBE_WIDTH-1:0] tkeep_arr [NUM_PORTS];
    logic [3:0]              tuser_arr [NUM_PORTS];

    // Unpack the flat per-port buses so the output mux can index them by grant.
    // The same loop builds the one-hot tready fan-out.
    for (genvar gi = 0; gi < NUM_PORTS; gi++) begin : g_port
        assign tdata_arr[gi] = i_tdata[gi*DATA_WIDTH +: DATA_WIDTH];
        assign tkeep_arr[gi] = i_tkeep[gi*STROBE_WIDTH +: STROBE_WIDTH];
        assign tuser_arr[gi] = i_tuser[gi*4 +: 4];
        assign o_tready[gi]  = o_busy && i_tready && (grant_q == 2'(gi));
    end

    // Round-robin search: first enabled requester at or above the pointer, wrapping.
    always_comb begin
        req   = i_tvalid & i_enable;
        pick  = ptr_q;
        cand  = ptr_q;
        found = 1'b0;
        for (int k = 0; k < NUM_PORTS; k++) begin
            cand = ptr_q + 2'(k);
            if (!found && req[cand]) begin
                pick  = cand;
                found = 1'b1;
            end
        end
    end

    // Merged stream: mirror the granted source while a grant is held, zero otherwise.
    always_comb begin
        o_busy   = (state_q == ST_GRANT);
        o_tvalid = o_busy && i_tvalid[grant_q];
        o_tlast  = o_busy && i_tlast[grant_q];
        o_tdata  = o_busy ? tdata_arr[grant_q] : '0;
        o_tkeep  = o_busy ? tkeep_arr[grant_q] : '0;
        o_tuser  = o_busy ? tuser_arr[grant_q] : 4'd0;
        o_tid    = o_busy ? {2'b00, grant_q} : 4'd0;
        o_pkt_count = pkt_count_q;
    end

    // Next-state logic. A grant is released only by an accepted tlast beat.
    // Enable changes therefore affect only the next arbitration.
    always_comb begin
        last_xfer   = o_tvalid && i_tready && o_tlast;
        state_d     = state_q;
        ptr_d       = ptr_q;
        grant_d     = grant_q;
        pkt_count_d = pkt_count_q;
        case (state_q)
            ST_IDLE: begin
                if (|req) begin
                    state_d = ST_GRANT;
                    grant_d = pick;
                end
            end
            default: begin
                if (last_xfer) begin
                    state_d     = ST_IDLE;
                    ptr_d       = grant_q + 2'd1;
                    pkt_count_d = pkt_count_q + 32'd1;
                end
            end
        endcase
    end

    // State registers. Reset aborts any packet in flight and restarts arbitration at port 0.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            ptr_q       <= 2'd0;
            grant_q     <= 2'd0;
            pkt_count_q <= 32'd0;
        end else begin
            state_q     <= state_d;
            ptr_q       <= ptr_d;
            grant_q     <= grant_d;
            pkt_count_q <= pkt_count_d;
        end
    end

endmodule

// File: tb/tb_axi4_stream_arbiter.sv
// tb_axi4_stream_arbiter: directed scenarios for the packet arbiter.
// Each source is modelled as a queue of beats. The beats the merged stream should
// carry are pushed to a scoreboard in the predicted grant order and popped as they
// are accepted downstream.
module tb_axi4_stream_arbiter;

    localparam int DW = 32;
    localparam int SW = 4;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic [3:0]      i_enable;
    logic [3:0]      i_tvalid;
    logic [4*DW-1:0] i_tdata;
    logic [3:0]      i_tlast;
    logic [4*SW-1:0] i_tkeep;
    logic [15:0]     i_tuser;
    logic [3:0]      o_tready;
    logic            o_tvalid;
    logic [DW-1:0]   o_tdata;
    logic            o_tlast;
    logic [SW-1:0]   o_tkeep;
    logic [3:0]      o_tuser;
    logic [3:0]      o_tid;
    logic            i_tready;
    logic            o_busy;
    logic [31:0]     o_pkt_count;

    typedef struct {
        int          port;
        logic [31:0] data;
        logic [3:0]  keep;
        logic [3:0]  user;
        logic        last;
    } beat_t;

    beat_t      srcq[$];
    beat_t      sbq[$];
    int         passed = 0;
    int         failed = 0;
    int         total  = 0;
    int         adv    = -1;
    int         cyc;
    logic       tog     = 1'b0;
    logic       mid_pkt = 1'b0;
    logic [3:0] hold    = 4'b0;

    axi4_stream_arbiter #(.DATA_WIDTH(DW), .STROBE_WIDTH(SW), .NUM_PORTS(4)) dut (
        .clk(clk), .rst(rst), .i_enable(i_enable), .i_tvalid(i_tvalid),
        .i_tdata(i_tdata), .i_tlast(i_tlast), .i_tkeep(i_tkeep), .i_tuser(i_tuser),
        .o_tready(o_tready), .o_tvalid(o_tvalid), .o_tdata(o_tdata), .o_tlast(o_tlast),
        .o_tkeep(o_tkeep), .o_tuser(o_tuser), .o_tid(o_tid), .i_tready(i_tready),
        .o_busy(o_busy), .o_pkt_count(o_pkt_count)
    );

    always #5 clk = ~clk;

    // Time limit on the whole run.
    initial begin
        #200000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
        total = total + 1;
        assert (obs === exp_v) passed = passed + 1;
        else begin
            failed = failed + 1;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp_v);
        end
    endtask

    function automatic int first_of(input int k);
        for (int i = 0; i < srcq.size(); i++)
            if (srcq[i].port == k) return i;
        return -1;
    endfunction

    task automatic load_pkt(input int port, input int pkt, input int nb, input bit expect_it);
        beat_t x;
        for (int b = 0; b < nb; b++) begin
            x.port = port;
            x.data = 32'hA000_0000 | (32'(port) << 16) | (32'(pkt) << 8) | 32'(b);
            x.keep = 4'(b + port + 1);
            x.user = 4'(port * 5 + pkt + b);
            x.last = (b == nb - 1);
            srcq.push_back(x);
            if (expect_it) sbq.push_back(x);
        end
    endtask

    task automatic drive();
        int idx;
        i_tvalid = '0; i_tdata = '0; i_tlast = '0; i_tkeep = '0; i_tuser = '0;
        for (int k = 0; k < 4; k++) begin
            idx = first_of(k);
            if (idx >= 0 && !hold[k]) begin
                i_tvalid[k]          = 1'b1;
                i_tdata[k*DW +: DW]  = srcq[idx].data;
                i_tkeep[k*SW +: SW]  = srcq[idx].keep;
                i_tuser[k*4 +: 4]    = srcq[idx].user;
                i_tlast[k]           = srcq[idx].last;
            end
        end
    endtask

    task automatic clear_all();
        srcq.delete();
        sbq.delete();
        mid_pkt = 1'b0;
        hold    = 4'b0;
        tog     = 1'b0;
        drive();
    endtask

    // Sample the merged stream on the falling edge. Compare it with the scoreboard,
    // and note which source, if any, completes a handshake at the next rising edge.
    task automatic monitor();
        beat_t e;
        adv = -1;
        for (int k = 0; k < 4; k++)
            if (i_tvalid[k] && o_tready[k]) adv = k;
        if (o_busy !== 1'b1) begin
            if (mid_pkt) chk("busy_held", o_busy, 1);
            chk("idle_tvalid", o_tvalid, 0);
            chk("idle_tready", o_tready, 0);
            chk("idle_tdata", o_tdata, 0);
            chk("idle_tlast", o_tlast, 0);
            chk("idle_tuser", o_tuser, 0);
            chk("idle_tid", o_tid, 0);
        end else if (sbq.size() == 0) begin
            chk("spurious_grant", o_busy, 0);
        end else begin
            e = sbq[0];
            chk("grant_tid", o_tid, e.port);
            chk("grant_tready", o_tready, i_tready ? (4'b0001 << e.port) : 4'b0000);
            chk("tvalid_follow", o_tvalid, i_tvalid[e.port]);
            if (o_tvalid === 1'b1 && i_tready === 1'b1) begin
                chk("beat_data", o_tdata, e.data);
                chk("beat_keep", o_tkeep, e.keep);
                chk("beat_user", o_tuser, e.user);
                chk("beat_last", o_tlast, e.last);
                void'(sbq.pop_front());
                mid_pkt = !e.last;
            end
        end
    endtask

    task automatic tick();
        int idx;
        @(negedge clk);
        monitor();
        @(posedge clk);
        #1;
        if (adv >= 0) begin
            idx = first_of(adv);
            if (idx >= 0) srcq.delete(idx);
        end
        if (tog) i_tready = ~i_tready;
        drive();
    endtask

    task automatic drain(input int budget, output int cycles);
        cycles = 0;
        while (sbq.size() != 0 && cycles < budget) begin
            tick();
            cycles = cycles + 1;
        end
        if (sbq.size() != 0) chk("drain_timeout", 64'(sbq.size()), 0);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    initial begin
        i_enable = 4'hF;
        i_tready = 1'b1;
        clear_all();
        load_pkt(0, 9, 1, 0);
        drive();
        repeat (2) @(posedge clk);
        #1;
        // Reset state while held in reset with a request pending.
        chk("rst_busy", o_busy, 0);
        chk("rst_tvalid", o_tvalid, 0);
        chk("rst_tready", o_tready, 0);
        chk("rst_count", o_pkt_count, 0);
        chk("rst_tid", o_tid, 0);
        clear_all();
        rst = 1'b0;

        // All four ports send 3-beat packets together: order 0,1,2,3 with one bubble each.
        for (int p = 0; p < 4; p++) load_pkt(p, 0, 3, 1);
        drive();
        drain(64, cyc);
        chk("t1_cycles", cyc, 16);
        chk("t1_pkt_count", o_pkt_count, 4);

        // Port 2 alone, downstream ready toggling, plus one source stall mid-packet.
        clear_all();
        do_reset();
        load_pkt(2, 0, 4, 1);
        i_tready = 1'b0;
        tog = 1'b1;
        drive();
        repeat (3) tick();
        hold[2] = 1'b1;
        drive();
        tick();
        hold[2] = 1'b0;
        drive();
        drain(40, cyc);
        chk("t2_pkt_count", o_pkt_count, 1);
        tog = 1'b0;
        i_tready = 1'b1;

        // Mask 1010 with every port requesting: grants 1,3,1 only.
        clear_all();
        do_reset();
        i_enable = 4'b1010;
        load_pkt(1, 0, 2, 1);
        load_pkt(3, 0, 2, 1);
        load_pkt(1, 1, 2, 1);
        load_pkt(0, 0, 2, 0);
        load_pkt(2, 0, 2, 0);
        drive();
        drain(64, cyc);
        chk("t3_cycles", cyc, 9);
        repeat (3) tick();
        chk("t3_pkt_count", o_pkt_count, 3);

        // Port 0 disabled after its first beat: packet completes, then single-beat port 2.
        clear_all();
        do_reset();
        i_enable = 4'hF;
        load_pkt(0, 0, 3, 1);
        load_pkt(2, 0, 1, 1);
        load_pkt(0, 1, 2, 0);
        drive();
        tick();
        tick();
        i_enable = 4'b1110;
        drive();
        drain(32, cyc);
        chk("t4_cycles", cyc, 4);
        repeat (3) tick();
        chk("t4_pkt_count", o_pkt_count, 2);

        // Reset during beat 2 of a port-3 packet; the next grant goes to the lowest requester.
        clear_all();
        i_enable = 4'hF;
        load_pkt(3, 0, 4, 1);
        drive();
        repeat (3) tick();
        rst = 1'b1;
        #1;
        chk("t5_tvalid", o_tvalid, 0);
        chk("t5_busy", o_busy, 0);
        chk("t5_count", o_pkt_count, 0);
        chk("t5_tready", o_tready, 0);
        clear_all();
        load_pkt(1, 0, 2, 1);
        load_pkt(3, 1, 2, 1);
        drive();
        @(posedge clk);
        #1;
        rst = 1'b0;
        drain(32, cyc);
        chk("t5_cycles", cyc, 6);
        chk("t5_pkt_count", o_pkt_count, 2);

        // Packet counter wraps from all-ones to zero.
        clear_all();
        force dut.pkt_count_d = 32'hFFFF_FFFF;
        @(posedge clk);
        #1;
        release dut.pkt_count_d;
        chk("t6_preload", o_pkt_count, 32'hFFFF_FFFF);
        load_pkt(0, 0, 1, 1);
        drive();
        drain(16, cyc);
        chk("t6_wrap", o_pkt_count, 0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/axi4_stream_arbiter.md
AXI4_STREAM_ARBITER -- requirements
Module: axi4_stream_arbiter

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32, width of each stream's tdata.
REQ-002 SHALL have parameter STROBE_WIDTH, default DATA_WIDTH/8, width of each tkeep.
REQ-003 SHALL have parameter NUM_PORTS, fixed at 4, number of upstream requesters.
REQ-004 clk  input  1  single clock; all logic on rising edge.
REQ-005 rst  input  1  reset, asynchronous and active-high.
REQ-006 i_enable  input  4  per-port arbitration enable mask; bit k gates new grants to port k.
REQ-007 i_tvalid  input  4  per-port tvalid; bit k is port k.
REQ-008 i_tdata  input  4*DATA_WIDTH  per-port tdata; port k at bits [k*DATA_WIDTH +: DATA_WIDTH].
REQ-009 i_tlast  input  4  per-port tlast.
REQ-010 i_tkeep  input  4*STROBE_WIDTH  per-port tkeep, packed as tdata.
REQ-011 i_tuser  input  16  per-port 4-bit tuser, packed as tdata.
REQ-012 o_tready  output  4  per-port tready.
REQ-013 o_tvalid  output  1  merged stream tvalid.
REQ-014 o_tdata  output  DATA_WIDTH  merged stream tdata.
REQ-015 o_tlast  output  1  merged stream tlast.
REQ-016 o_tkeep  output  STROBE_WIDTH  merged stream tkeep.
REQ-017 o_tuser  output  4  merged stream tuser.
REQ-018 o_tid  output  4  index of granted source port, zero-extended.
REQ-019 i_tready  input  1  downstream tready.
REQ-020 o_busy  output  1  high while a grant is held.
REQ-021 o_pkt_count  output  32  total packets forwarded (tlast beats accepted).

Function
REQ-022 SHALL implement FSM with states IDLE and GRANT.
REQ-023 IDLE: when any (i_tvalid & i_enable) bit set, SHALL register grant to first requesting enabled port searching from pointer upward, modulo 4, and move to GRANT next cycle.
REQ-024 IDLE with no enabled request SHALL remain IDLE; o_tvalid=0, o_tready=0.
REQ-025 GRANT: o_tvalid/o_tdata/o_tlast/o_tkeep/o_tuser SHALL combinationally mirror the granted port; o_tid=granted index.
REQ-026 GRANT: o_tready[g]=i_tready for granted port g; all other o_tready bits SHALL be 0.
REQ-027 Beat transfers when o_tvalid && i_tready; grant SHALL hold across any number of beats and stalls until a tlast beat transfers.
REQ-028 On tlast transfer: SHALL return to IDLE, set pointer to (g+1) mod 4, increment o_pkt_count (wraps 0xFFFFFFFF->0).
REQ-029 Latency: first beat appears on output the cycle after request seen in IDLE; one idle bubble between consecutive packets.
REQ-030 Clearing i_enable[g] mid-packet SHALL NOT revoke the grant; mask affects only new arbitration.
REQ-031 Source deasserting i_tvalid mid-packet SHALL hold grant; o_tvalid follows low.
REQ-032 Single-beat packet (tvalid and tlast same beat) SHALL be forwarded and released in one GRANT cycle.
REQ-033 o_busy SHALL equal (state==GRANT).
REQ-034 Outputs outside GRANT: o_tvalid, o_tlast, o_tdata, o_tkeep, o_tuser, o_tid SHALL be 0.

Reset
REQ-035 rst SHALL asynchronously force state IDLE, pointer 0, grant 0, o_pkt_count 0, all o_tready 0, o_tvalid 0, o_busy 0.
REQ-036 rst asserted mid-packet SHALL abort the packet immediately; no partial-packet recovery; first arbitration after release starts at port 0.

Verification
REQ-037 All 4 ports enabled, each sending one 3-beat packet simultaneously, i_tready=1 -> o_tid sequence 0,1,2,3, one bubble between packets, o_pkt_count=4.
REQ-038 Port 2 alone, 4-beat packet, i_tready toggling every cycle -> all 4 beats delivered in order, o_tready only bit 2, o_busy held until tlast accepted.
REQ-039 i_enable=4'b1010, all ports requesting -> only ports 1 and 3 granted, alternating 1,3,1.
REQ-040 Port 0 granted, i_enable[0] cleared after beat 1 -> packet completes, then grant moves to next enabled requester.
REQ-041 rst pulsed during beat 2 of a port-3 packet -> o_tvalid=0, o_busy=0, o_pkt_count=0 same cycle; next grant goes to lowest requesting port.
REQ-042 o_pkt_count preloaded path: 2^32 packets (or forced counter 0xFFFFFFFF) plus one packet -> count reads 0.
